fp_mult_issue_ctrl: RTL and testbench

//   Flow-control shell around the pipelined FP32 multiplier core fp_mult_ppl.
//   - Accepts operand pairs on a ready/valid input and issues them into the core.
//   - Tracks each in-flight product with a valid shift register.
//   - Captures the core's q output into a result FIFO and drains it on a

---
 rtl/fp_mult_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_fp_mult_issue_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_issue_ctrl.sv
// Flow-control shell for the free-running pipelined FP32 multiplier fp_mult_ppl:
// issues operand pairs, tracks in-flight products and buffers results in a FIFO.
module fp_mult_issue_ctrl #(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        mult_en,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [OW-1:0] OCC_ONE  = OW'(1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic              mult_en_q;
  logic [31:0]       mult_a_q,  mult_a_d;
  logic [31:0]       mult_b_q,  mult_b_d;
  logic [LATENCY:0]  vld_sr_q,  vld_sr_d;
  logic [PW-1:0]     wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q,  rd_ptr_d;
  logic [PW:0]       count_q,   count_d;
  logic [OW-1:0]     occ_q,     occ_d;
  logic [31:0]       mem [DEPTH];

  logic issue;
  logic pop;
  logic fifo_wr;

  // in_ready depends only on registers so the upstream can never form a loop through in_valid.
  assign in_ready  = mult_en_q & (occ_q != OCC_FULL);
  assign out_valid = (count_q != '0);
  assign out_data  = mem[rd_ptr_q];
  assign busy      = (occ_q != '0);
  assign mult_en   = mult_en_q;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;

  assign issue   = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign fifo_wr = vld_sr_q[LATENCY];

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    occ_d    = occ_q;
    vld_sr_d = {vld_sr_q[LATENCY-1:0], issue};

    if (issue) begin
      mult_a_d = in_a;
      mult_b_d = in_b;
    end
    if (fifo_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({fifo_wr, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Credits are taken at issue, so a slot is reserved before the product exists.
    case ({issue, pop})
      2'b10:   occ_d = occ_q + OCC_ONE;
      2'b01:   occ_d = occ_q - OCC_ONE;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mult_en_q <= 1'b0;
      mult_a_q  <= '0;
      mult_b_q  <= '0;
      vld_sr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      occ_q     <= '0;
    end else begin
      mult_en_q <= 1'b1;
      mult_a_q  <= mult_a_d;
      mult_b_q  <= mult_b_d;
      vld_sr_q  <= vld_sr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      occ_q     <= occ_d;
    end
  end

  // NOTE: the storage array has no reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr_q] <= mult_q;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(fifo_wr && (count_q == CNT_FULL)));
  a_occ_bound:   assert property (@(posedge clk) disable iff (!reset_n)
                                  occ_q <= OCC_FULL);

endmodule

// File: tb/tb_fp_mult_issue_ctrl.sv
// Randomised and directed bench for fp_mult_issue_ctrl with a behavioural FP32 core
// model and a transaction-level scoreboard (issue order, visibility time, credits).
module tb_fp_mult_issue_ctrl;

  localparam int LATENCY = 3;
  localparam int DEPTH   = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mult_en;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [31:0] mult_q;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  fp_mult_issue_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_q(mult_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real fp32_to_real(input logic [31:0] x);
    real m;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    m = m * (2.0 ** e);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    real         r;
    logic [63:0] d;
    int          e;
    r = fp32_to_real(a) * fp32_to_real(b);
    if (r == 0.0) return {a[31] ^ b[31], 31'd0};
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    if (e <= 0)   return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hff, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  // Core model: free-running, not cleared by reset, so stale products really do emerge.
  logic [31:0] core_pipe [LATENCY];
  always @(posedge clk) begin
    if (mult_en) begin
      core_pipe[0] <= fp32_mul(mult_a, mult_b);
      for (int k = 1; k < LATENCY; k++) core_pipe[k] <= core_pipe[k-1];
    end
  end
  assign mult_q = core_pipe[LATENCY-1];

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  int          since_rst = 0;

  logic        obs_ir, exp_ir, obs_ov, exp_ov, obs_busy, exp_busy, acc, popd;
  logic [31:0] got, exp_data;

  // One clock cycle: drive, sample mid-cycle, advance the transaction model, take the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic rdy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    #1;
    obs_ir   = in_ready;
    obs_ov   = out_valid;
    obs_busy = busy;
    got      = out_data;
    exp_ir   = (since_rst >= 1) && (sb.size() != DEPTH);
    exp_ov   = (sb.size() != 0) && (cyc >= sb[0].due);
    exp_busy = (sb.size() != 0);
    exp_data = (sb.size() != 0) ? sb[0].data : 32'h0;
    acc      = v && obs_ir;
    popd     = rdy && obs_ov;
    if (popd && sb.size() != 0) void'(sb.pop_front());
    if (acc) sb.push_back('{fp32_mul(a, b), cyc + LATENCY + 2});
    @(posedge clk);
    #1;
    cyc++;
    since_rst++;
  endtask

  task automatic drain(output int pops);
    int n;
    pops = 0;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      step(1'b0, 32'h0, 32'h0, 1'b1);
      n++;
      tests_run++;
      if (obs_ov !== exp_ov) begin
        tests_failed++;
        $display("FAIL drain_out_valid got=%b exp=%b cyc=%0d", obs_ov, exp_ov, cyc);
      end
      tests_run++;
      if (obs_ir !== exp_ir) begin
        tests_failed++;
        $display("FAIL drain_in_ready got=%b exp=%b cyc=%0d", obs_ir, exp_ir, cyc);
      end
      if (popd) begin
        pops++;
        tests_run++;
        if (got !== exp_data) begin
          tests_failed++;
          $display("FAIL drain_data got=%h exp=%h cyc=%0d", got, exp_data, cyc);
        end
      end
    end
    tests_run++;
    if (sb.size() != 0 || out_valid) begin
      tests_failed++;
      $display("FAIL drain_timeout left=%0d out_valid=%b exp_left=0", sb.size(), out_valid);
      sb.delete();
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_a = 32'h3f800000;
    in_b = 32'h40000000;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (mult_en !== 1'b0)   begin tests_failed++; $display("FAIL reset_mult_en got=%b exp=0", mult_en); end
    tests_run++;
    if (in_ready !== 1'b0)  begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++;
    if (busy !== 1'b0)      begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++;
    if ({mult_a, mult_b} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_mult_ab got=%h/%h exp=0/0", mult_a, mult_b);
    end
    reset_n = 1'b1;
    since_rst = 0;
    sb.delete();
  endtask

  task automatic test_post_reset_ramp();
    int pops;
    step(1'b1, 32'h3f800000, 32'h40000000, 1'b0);
    tests_run++;
    if (obs_ir !== 1'b0) begin tests_failed++; $display("FAIL ramp_in_ready_edge0 got=%b exp=0", obs_ir); end
    tests_run++;
    if (mult_en !== 1'b1) begin tests_failed++; $display("FAIL ramp_mult_en_edge1 got=%b exp=1", mult_en); end
    step(1'b1, 32'h3f800000, 32'h40000000, 1'b0);
    tests_run++;
    if (acc !== 1'b1) begin tests_failed++; $display("FAIL ramp_first_accept got=%b exp=1", acc); end
    drain(pops);
    tests_run++;
    if (pops != 1) begin tests_failed++; $display("FAIL ramp_pops got=%0d exp=1", pops); end
  endtask

  task automatic test_single_op();
    int j;
    step(1'b1, 32'h3f800000, 32'h40840000, 1'b0);
    tests_run++;
    if (acc !== 1'b1) begin tests_failed++; $display("FAIL single_accept got=%b exp=1", acc); end
    for (j = 1; j <= 20; j++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0);
      if (obs_ov) break;
    end
    tests_run++;
    if (j - 1 != LATENCY + 1) begin
      tests_failed++;
      $display("FAIL single_latency got=%0d exp=%0d", j - 1, LATENCY + 1);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1);
    tests_run++;
    if (popd !== 1'b1 || got !== 32'h40840000) begin
      tests_failed++;
      $display("FAIL single_data got=%h pop=%b exp=40840000", got, popd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ia [3] = '{32'h3f800000, 32'h42ff8000, 32'h45000000};
    logic [31:0] ib [3] = '{32'h40840000, 32'h41de0000, 32'h45000000};
    logic [31:0] ex [3] = '{32'h40840000, 32'h455d9100, 32'h4a800000};
    int          pcyc [3];
    int          n = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, ia[i], ib[i], 1'b1);
      tests_run++;
      if (acc !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept%0d got=%b exp=1", i, acc); end
    end
    for (int k = 0; k < 20 && n < 3; k++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1);
      if (popd) begin
        pcyc[n] = cyc;
        tests_run++;
        if (got !== ex[n]) begin
          tests_failed++;
          $display("FAIL b2b_data%0d got=%h exp=%h", n, got, ex[n]);
        end
        n++;
      end
    end
    tests_run++;
    if (n != 3 || pcyc[1] != pcyc[0] + 1 || pcyc[2] != pcyc[1] + 1) begin
      tests_failed++;
      $display("FAIL b2b_consecutive got=%0d pops exp=3 on consecutive cycles", n);
    end
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    int pops;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, rand_fp(), rand_fp(), 1'b0);
      if (acc) accepts++;
      tests_run++;
      if (obs_ir !== exp_ir) begin
        tests_failed++;
        $display("FAIL bp_in_ready%0d got=%b exp=%b", i, obs_ir, exp_ir);
      end
    end
    tests_run++;
    if (accepts != DEPTH) begin tests_failed++; $display("FAIL bp_accepts got=%0d exp=%0d", accepts, DEPTH); end
    repeat (LATENCY + 2) step(1'b0, 32'h0, 32'h0, 1'b0);
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_full_state got=busy%b/ir%b/ov%b exp=busy1/ir0/ov1", busy, in_ready, out_valid);
    end
    drain(pops);
    tests_run++;
    if (pops != DEPTH) begin tests_failed++; $display("FAIL bp_drain_count got=%0d exp=%0d", pops, DEPTH); end
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_recover got=ir%b/busy%b exp=ir1/busy0", in_ready, busy);
    end
  endtask

  task automatic test_random();
    int accepts = 0;
    int n = 0;
    int pops;
    while (accepts < 100 && n < 3000) begin
      step($urandom_range(0, 3) != 0, rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
      n++;
      if (acc) accepts++;
      tests_run++;
      if (obs_ir !== exp_ir) begin
        tests_failed++;
        $display("FAIL rand_in_ready got=%b exp=%b cyc=%0d", obs_ir, exp_ir, cyc);
      end
      tests_run++;
      if (obs_ov !== exp_ov) begin
        tests_failed++;
        $display("FAIL rand_out_valid got=%b exp=%b cyc=%0d", obs_ov, exp_ov, cyc);
      end
      tests_run++;
      if (obs_busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL rand_busy got=%b exp=%b cyc=%0d", obs_busy, exp_busy, cyc);
      end
      if (popd) begin
        tests_run++;
        if (got !== exp_data) begin
          tests_failed++;
          $display("FAIL rand_data got=%h exp=%h cyc=%0d", got, exp_data, cyc);
        end
      end
    end
    tests_run++;
    if (accepts < 100) begin tests_failed++; $display("FAIL rand_timeout got=%0d accepts exp=100", accepts); end
    drain(pops);
  endtask

  task automatic test_reset_mid_flight();
    int pops;
    for (int i = 0; i < 5; i++) step(1'b1, rand_fp(), rand_fp(), 1'b0);
    repeat (2) step(1'b0, 32'h0, 32'h0, 1'b0);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || mult_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear got=ov%b/busy%b/en%b exp=ov0/busy0/en0", out_valid, busy, mult_en);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    since_rst = 0;
    sb.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1);
      tests_run++;
      if (obs_ov !== 1'b0 || obs_ir !== exp_ir) begin
        tests_failed++;
        $display("FAIL midrst_stale%0d got=ov%b/ir%b exp=ov0/ir%b", i, obs_ov, obs_ir, exp_ir);
      end
    end
    step(1'b1, 32'h42ff8000, 32'h41de0000, 1'b0);
    tests_run++;
    if (acc !== 1'b1) begin tests_failed++; $display("FAIL midrst_accept got=%b exp=1", acc); end
    drain(pops);
    tests_run++;
    if (pops != 1) begin tests_failed++; $display("FAIL midrst_pops got=%0d exp=1", pops); end
  endtask

  initial begin
    test_reset();
    test_post_reset_ramp();
    test_single_op();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_flight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
